// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: AES-256 CTR stream engine; cfg_* starts a message, in_*/out_* carry data blocks, core_* drive an external AES-256 encrypt core, busy/done/ctr_wrap report status
module aes_ctr_stream #(
  parameter int CTR_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [255:0]     cfg_key_i,
  input  logic [127:0]     cfg_ctr_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             out_last_o,
  output logic             core_start_o,
  output logic [255:0]     core_key_o,
  output logic [127:0]     core_block_o,
  input  logic             core_done_i,
  input  logic [127:0]     core_result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ctr_wrap_o
);
  typedef enum logic [2:0] {IDLE, GEN, WAIT, MIX, OUT} state_t;
  localparam logic [127:0] LOW_MASK = {128{1'b1}} >> (128 - CTR_W);
  state_t state_q, state_d;
  logic [255:0] key_q;
  logic [127:0] ctr_q, ks_q, out_q, ctr_inc;
  logic [LEN_W-1:0] rem_q;
  logic wrap_q, done_q, ovf, cfg_hs, in_hs, out_hs, last;
  assign cfg_ready_o = ~rst & (state_q == IDLE);
  assign core_start_o = ~rst & (state_q == GEN);
  assign in_ready_o = ~rst & (state_q == MIX);
  assign out_valid_o = ~rst & (state_q == OUT);
  assign busy_o = ~rst & (state_q != IDLE);
  assign last = rem_q == LEN_W'(1);
  assign out_last_o = out_valid_o & last;
  assign cfg_hs = cfg_valid_i & cfg_ready_o;
  assign in_hs = in_valid_i & in_ready_o;
  assign out_hs = out_valid_o & out_ready_i;
  assign ctr_inc = (ctr_q & ~LOW_MASK) | ((ctr_q + 128'd1) & LOW_MASK);
  assign ovf = &(ctr_q | ~LOW_MASK);
  assign core_key_o = key_q;
  assign core_block_o = ctr_q;
  assign out_data_o = out_q;
  assign done_o = done_q;
  assign ctr_wrap_o = wrap_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (cfg_hs && cfg_len_i != '0) ? GEN : IDLE;
      GEN:  state_d = WAIT;
      WAIT: state_d = core_done_i ? MIX : WAIT;
      MIX:  state_d = in_valid_i ? OUT : MIX;
      OUT:  state_d = out_ready_i ? (last ? IDLE : GEN) : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q <= '0;
      ctr_q <= '0;
      rem_q <= '0;
      ks_q <= '0;
      out_q <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= (cfg_hs && cfg_len_i == '0) || (out_hs && last);
      if (cfg_hs) begin
        key_q <= cfg_key_i;
        ctr_q <= cfg_ctr_i;
        rem_q <= cfg_len_i;
        wrap_q <= 1'b0;
      end
      if (core_done_i && state_q == WAIT) ks_q <= core_result_i;
      if (in_hs) out_q <= in_data_i ^ ks_q;
      if (out_hs) begin
        rem_q <= rem_q - LEN_W'(1);
        ctr_q <= ctr_inc;
        wrap_q <= wrap_q | ovf;
      end
    end
  end
endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream: randomized scoreboard bench for aes_ctr_stream with an AES-256 reference core
module tb_aes_ctr_stream;
  localparam int LAT = 14;
  localparam logic [255:0] K = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  typedef struct packed {
    logic [127:0] data;
    logic last;
    logic wrap;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid_i, cfg_ready_o, in_valid_i, in_ready_o, out_valid_o, out_ready_i, out_last_o;
  logic core_start_o, core_done_i, busy_o, done_o, ctr_wrap_o;
  logic [255:0] cfg_key_i, core_key_o, cur_key;
  logic [127:0] cfg_ctr_i, in_data_i, out_data_o, core_block_o, core_result_i, held;
  logic [15:0] cfg_len_i;
  logic [7:0] sbox [256];
  exp_t exp_q[$];
  logic [127:0] blk_q[$], in_q[$];
  int n_tests = 0, n_fail = 0, starts = 0, dones = 0, outs = 0, rdy_pct = 100;
  always #5 clk = ~clk;
  aes_ctr_stream dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_key_i(cfg_key_i),
    .cfg_ctr_i(cfg_ctr_i), .cfg_len_i(cfg_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .core_start_o(core_start_o), .core_key_o(core_key_o), .core_block_o(core_block_o),
    .core_done_i(core_done_i), .core_result_i(core_result_i),
    .busy_o(busy_o), .done_o(done_o), .ctr_wrap_o(ctr_wrap_o)
  );
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction
  function automatic logic [127:0] aes256(input logic [255:0] key, input logic [127:0] blk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0] b [16];
    logic [7:0] n [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] s;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) tmp = subw(tmp);
      w[i] = w[i-8] ^ tmp;
    end
    s = blk ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) n[k+4*c] = sbox[b[k+4*((c+k)%4)]];
      if (r < 14)
        for (int c = 0; c < 4; c++) begin
          a0 = n[4*c];
          a1 = n[4*c+1];
          a2 = n[4*c+2];
          a3 = n[4*c+3];
          n[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          n[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          n[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          n[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = n[i];
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, 256'({core_start_o, out_valid_o, out_last_o, in_ready_o, busy_o, done_o, ctr_wrap_o}), 256'(0));
    chk({tag, "_data"}, {out_data_o, core_block_o}, 256'(0));
    chk({tag, "_key"}, core_key_o, 256'(0));
  endtask
  task automatic load(input logic [255:0] key, input logic [127:0] ctr, input int len,
                      input bit fixed, input logic [127:0] pt0, input logic [127:0] exp0);
    logic [127:0] c, pt;
    logic w;
    exp_t e;
    w = 1'b0;
    for (int i = 0; i < len; i++) begin
      c = {ctr[127:32], ctr[31:0] + 32'(i)};
      w = w | (c[31:0] == 32'hffffffff);
      pt = (fixed && i == 0) ? pt0 : rand128();
      e.data = (fixed && i == 0) ? exp0 : pt ^ aes256(key, c);
      e.last = (i == len - 1);
      e.wrap = w;
      blk_q.push_back(c);
      in_q.push_back(pt);
      exp_q.push_back(e);
    end
  endtask
  task automatic send_cfg(input logic [255:0] key, input logic [127:0] ctr, input int len);
    int t;
    cur_key = key;
    @(posedge clk);
    #1;
    cfg_valid_i = 1'b1;
    cfg_key_i = key;
    cfg_ctr_i = ctr;
    cfg_len_i = 16'(len);
    t = 0;
    @(negedge clk);
    while (!cfg_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    cfg_valid_i = 1'b0;
  endtask
  task automatic run_msg(input string tag, input logic [255:0] key, input logic [127:0] ctr, input int len,
                         input bit fixed, input logic [127:0] pt0, input logic [127:0] exp0);
    int s0, d0, o0, t;
    load(key, ctr, len, fixed, pt0, exp0);
    s0 = starts;
    d0 = dones;
    o0 = outs;
    send_cfg(key, ctr, len);
    t = 0;
    while (dones == d0 && t < 400 * (len + 1)) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, 256'(dones - d0), 256'(1));
    chk({tag, "_start_count"}, 256'(starts - s0), 256'(len));
    chk({tag, "_out_count"}, 256'(outs - o0), 256'(len));
    chk({tag, "_drained"}, 256'(exp_q.size() + blk_q.size()), 256'(0));
    chk({tag, "_idle"}, 256'({busy_o, cfg_ready_o}), 256'(2'b01));
    exp_q.delete();
    blk_q.delete();
    in_q.delete();
  endtask
  initial begin
    bit hs;
    in_valid_i = 1'b0;
    in_data_i = '0;
    forever begin
      @(negedge clk);
      hs = !rst && in_valid_i && in_ready_o;
      @(posedge clk);
      #1;
      if (hs && in_q.size() > 0) void'(in_q.pop_front());
      in_valid_i = in_q.size() > 0 && $urandom_range(0, 3) != 0;
      in_data_i = in_q.size() > 0 ? in_q[0] : rand128();
    end
  end
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready_i = $urandom_range(0, 99) < rdy_pct;
    end
  end
  initial begin
    int cnt;
    logic [127:0] res;
    cnt = 0;
    res = '0;
    held = '0;
    core_done_i = 1'b0;
    core_result_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && core_start_o) begin
        cnt = LAT;
        held = core_block_o;
        res = aes256(core_key_o, core_block_o);
      end
      @(posedge clk);
      #1;
      core_done_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done_i = 1'b1;
          core_result_i = res;
        end
      end
    end
  end
  initial begin
    bit stall, wchk;
    logic wexp;
    logic [127:0] prev;
    exp_t e;
    stall = 0;
    wchk = 0;
    wexp = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
        wchk = 0;
      end else begin
        if (wchk) begin
          chk("ctr_wrap", 256'(ctr_wrap_o), 256'(wexp));
          wchk = 0;
        end
        if (out_valid_o) begin
          if (stall) chk("out_stable", 256'(out_data_o), 256'(prev));
          if (out_ready_i) begin
            outs++;
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL out_unexpected: got %h expected no output", out_data_o);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", 256'(out_data_o), 256'(e.data));
              chk("out_last", 256'(out_last_o), 256'(e.last));
              wchk = 1;
              wexp = e.wrap;
            end
          end
          stall = !out_ready_i;
          prev = out_data_o;
        end else stall = 0;
        if (core_start_o) begin
          starts++;
          chk("core_key", core_key_o, cur_key);
          if (blk_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL core_start_unexpected: got block %h expected no start", core_block_o);
          end else chk("core_block", 256'(core_block_o), 256'(blk_q.pop_front()));
        end
        if (core_done_i && busy_o) chk("core_block_hold", 256'(core_block_o), 256'(held));
        if (done_o) dones++;
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] inv;
    logic [127:0] c;
    logic [255:0] k;
    int s0, d0, t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    cfg_valid_i = 1'b0;
    cfg_key_i = '0;
    cfg_ctr_i = '0;
    cfg_len_i = '0;
    cur_key = '0;
    chk("aes_ref_f55", 256'(aes256(K, C)), 256'(128'h0bdf7df1591716335e9a8b15c860c502));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cfg_ready", 256'({cfg_ready_o, busy_o}), 256'(2'b10));
    run_msg("f55_len1", K, C, 1, 1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h601ec313775789a5b7a7f504bbf3d228);
    run_msg("f55_len3", K, C, 3, 1'b0, '0, '0);
    run_msg("wrap", rand128() ^ (256'(1) << 200), 128'h00112233445566778899aabbffffffff, 2, 1'b0, '0, '0);
    chk("wrap_final", 256'(ctr_wrap_o), 256'(1));
    run_msg("len0", K, C, 0, 1'b0, '0, '0);
    chk("len0_wrap_cleared", 256'(ctr_wrap_o), 256'(0));
    rdy_pct = 50;
    run_msg("rand16", {rand128(), rand128()}, rand128(), 16, 1'b0, '0, '0);
    k = {rand128(), rand128()};
    c = {rand128() >> 32, 32'hffffffff};
    load(k, c, 4, 1'b0, '0, '0);
    s0 = starts;
    send_cfg(k, c, 4);
    t = 0;
    while (starts - s0 < 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_blk2", 256'(starts - s0), 256'(2));
    chk("abort_wrap_before", 256'(ctr_wrap_o), 256'(1));
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_rst("abort");
    exp_q.delete();
    blk_q.delete();
    in_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cfg_ready", 256'({cfg_ready_o, busy_o}), 256'(2'b10));
    d0 = dones;
    repeat (25) @(negedge clk);
    chk("abort_no_done", 256'(dones - d0), 256'(0));
    chk("abort_quiet", 256'({busy_o, out_valid_o, core_start_o, in_ready_o}), 256'(0));
    chk_rst("abort_after");
    run_msg("after_abort", {rand128(), rand128()}, rand128(), 5, 1'b0, '0, '0);
    rdy_pct = 70;
    for (int i = 0; i < 3; i++)
      run_msg("rand_near_wrap", {rand128(), rand128()}, {rand128() >> 32, 32'hffffffff - 32'($urandom_range(0, 3))},
              $urandom_range(1, 6), 1'b0, '0, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_ctr_stream.md
AES_CTR_STREAM -- requirements
Module: aes_ctr_stream

Interface
REQ-001 Parameter CTR_W, default 32: number of low counter-block bits that increment; legal range 8..128.
REQ-002 Parameter LEN_W, default 16: width of the message block count.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_valid/cfg_ready  input/output  1/1  handshake that starts a message.
REQ-006 cfg_key  input  256  AES-256 key, captured on cfg handshake.
REQ-007 cfg_ctr  input  128  initial counter block, captured on cfg handshake.
REQ-008 cfg_len  input  LEN_W  number of 128-bit blocks in the message.
REQ-009 in_valid/in_ready/in_data  input/output/input  1/1/128  plaintext or ciphertext stream.
REQ-010 out_valid/out_ready/out_data/out_last  output/input/output/output  1/1/128/1  result stream.
REQ-011 core_start/core_key/core_block  output  1/256/128  request to the external AES-256 encrypt core.
REQ-012 core_done/core_result  input  1/128  one-cycle completion pulse with keystream block.
REQ-013 busy/done/ctr_wrap  output  1/1/1  status outputs.

Function
REQ-014 States: IDLE, GEN, WAIT, MIX, OUT.
REQ-015 cfg_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-016 IDLE: on cfg_valid&cfg_ready, latch key, counter and length, and clear ctr_wrap.
  - If cfg_len = 0: pulse done for 1 cycle, stay in IDLE, emit no output.
  - Otherwise: go to GEN.
REQ-017 GEN: core_start = 1 for exactly one cycle, with core_block = current counter and core_key = latched key; then go to WAIT.
REQ-018 WAIT: hold core_block and core_key stable. On core_done, register core_result as keystream and go to MIX. core_done outside WAIT is ignored.
REQ-019 MIX: in_ready = 1.
  - On in_valid, out_data <= in_data XOR keystream and go to OUT.
  - in_ready = 0 in all other states.
REQ-020 OUT: out_valid = 1, with out_data held stable until out_ready.
  - out_last = 1 when this is the final block of the message.
REQ-021 On out_valid&out_ready:
  - Decrement remaining count and increment the counter.
  - If the block was the last: pulse done for 1 cycle and go to IDLE.
  - Otherwise: go to GEN.
REQ-022 Counter increment applies to bits [CTR_W-1:0] modulo 2^CTR_W; bits [127:CTR_W] never change.
REQ-023 ctr_wrap is set, and stays set, when a low-field increment overflows from all-ones to zero. It is cleared only by rst or a new cfg handshake.
REQ-024 Minimum per-block latency, counted from the GEN cycle to out_valid: 1 (GEN) + core latency + 1 (MIX, with in_valid already high) cycles.
REQ-025 Backpressure on out_ready or starvation on in_valid stalls the FSM with no loss or duplication of data.
REQ-026 The function is symmetric: the same operation encrypts and decrypts.

Reset
REQ-027 While rst is high:
  - State = IDLE.
  - core_start, out_valid, out_last, in_ready, busy, done and ctr_wrap = 0.
  - out_data, core_block and core_key = 0.
  - Remaining count = 0.
  - cfg_ready = 1 from the first cycle after rst deasserts.
REQ-028 rst asserted mid-message aborts the message immediately: no done pulse, and any core_done arriving after reset is ignored.

Verification
REQ-029 SP800-38A F.5.5 vector, len = 1, with a behavioural AES core model of 14-cycle latency:
  - cfg_key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, cfg_ctr = f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, in_data = 6bc1bee22e409f96e93d7e117393172a.
  - Required: out_data = 601ec313775789a5b7a7f504bbf3d228, out_last = 1, then one done pulse.
REQ-030 Same key and counter, len = 3:
  - core_block sequence = ...fdfeff, ...fdff00, ...fdff01.
  - out_last = 1 only on the third block.
  - Exactly 3 core_start pulses.
REQ-031 Wrap test, CTR_W = 32, cfg_ctr = 00112233445566778899aabbffffffff, len = 2:
  - Second core_block = 00112233445566778899aabb00000000.
  - ctr_wrap = 1 after the first output handshake.
REQ-032 cfg_len = 0: cfg accepted, done pulses for 1 cycle, with no core_start and no out_valid.
REQ-033 Random out_ready (50%) and random in_valid gaps over 16 blocks: output equals the reference XOR stream, and out_data is stable while out_valid & ~out_ready.
REQ-034 rst during WAIT of block 2 of 4, with core_done then arriving:
  - Outputs and status return to their REQ-027 values, with no done pulse.
  - A new message afterwards produces correct results.
